clock_core: RTL and testbench
=============================

CLOCK_CORE -- requirements
Module: clock_core

Interface
REQ-001 Parameter DIV, default 1000: rising edges of tick_in per one-second advance; legal range 1..65535.
REQ-002 CP  input  1  system clock; all flops on posedge CP.
REQ-003 CR  input  1  reset, synchronous, active-high.
REQ-004 tick_in  input  1  divided square wave from the frequency divider; treated as asynchronous level.
REQ-005 set_mode  input  1  1 = time-setting mode, timekeeping halted.
REQ-006 set_sel  input  2  field select: 00 = seconds, 01 = minutes, 10 = hours, 11 = none.
REQ-007 set_inc  input  1  one-CP-cycle pulse (debounced upstream) that increments the selected field.
REQ-008 hour  output  8  BCD hours 00..23, [7:4] tens, [3:0] units.
REQ-009 min  output  8  BCD minutes 00..59.
REQ-010 sec  output  8  BCD seconds 00..59.
REQ-011 sec_pulse  output  1  one-CP-cycle strobe on every run-mode second advance.
REQ-012 chime  output  1  hourly chime; present only with the macro (REQ-031).

Function
REQ-013 tick_in SHALL pass a 2-flop synchronizer; a third flop SHALL yield edge = sync & ~prev, at most one CP cycle per rising edge.
REQ-014 Edge-to-count latency SHALL be 3 CP cycles from tick_in rise to prescaler update.
REQ-015 Prescaler pcnt (16 bit) SHALL count edges 0..DIV-1; on edge with pcnt == DIV-1 it SHALL wrap to 0 and assert sec_tick internally.
REQ-016 On sec_tick in run mode, sec, min and hour SHALL update in the same cycle sec_tick is asserted, with sec_pulse high in that cycle.
REQ-017 Seconds SHALL count BCD 00..59; 59 -> 00 SHALL carry to minutes in the same cycle.
REQ-018 Minutes SHALL count BCD 00..59; 59 -> 00 with carry SHALL carry to hours in the same cycle.
REQ-019 Hours SHALL count BCD 00..23; 23:59:59 -> 00:00:00 in one cycle.
REQ-020 Units digit SHALL roll 9 -> 0 and increment tens; no BCD digit shall ever hold A..F.
REQ-021 While set_mode = 1: pcnt held at 0, edges ignored, sec_pulse held 0.
REQ-022 set_inc with set_mode = 1 SHALL increment only the selected field and wrap it (59 -> 00, 23 -> 00), with no carry into the next field.
REQ-023 set_inc with set_sel = 00 SHALL clear seconds to 00, not increment them.
REQ-024 set_inc with set_mode = 0 or set_sel = 11 SHALL be ignored.
REQ-025 On the set_mode 1 -> 0 transition, pcnt SHALL restart from 0, so the first advance occurs DIV edges later.
REQ-026 If an edge and set_mode rising occur in the same cycle, set_mode SHALL win and no count occurs.

Reset
REQ-027 With CR = 1 at a CP edge: hour, min, sec = 8'h00; pcnt = 0; sec_pulse = 0; chime = 0; synchronizer and edge flops = 0.
REQ-028 CR SHALL dominate set_mode, set_inc and edges in the same cycle.
REQ-029 If tick_in is high when CR is released, one rising edge SHALL be detected once the synchronizer fills.
REQ-030 Reset mid-second SHALL discard the partial prescaler count.

Configuration
REQ-031 Macro HOURLY_CHIME_EN: when defined, chime SHALL be registered high while min = 59 and sec in 55..59 in run mode, and low otherwise (low in set mode).
REQ-032 Without HOURLY_CHIME_EN, the chime port and all of its logic SHALL be absent.

Verification (DIV = 4 for simulation)
REQ-033 CR pulse, then 8 tick_in periods -> exactly 2 sec_pulse; sec = 8'h02; first pulse 3 CP cycles after the 4th tick_in rise.
REQ-034 Preload 23:59:59 via set mode, exit set mode, apply 4 edges -> 00:00:00 in one cycle with a single sec_pulse.
REQ-035 Set mode, set_sel = 01, min = 59, set_inc -> min = 00 and hour unchanged; set_sel = 00, set_inc -> sec = 00.
REQ-036 Run mode at 10 edges toward 09 s -> sec steps 8'h09 to 8'h10, never 8'h0A.
REQ-037 CR asserted with pcnt = 2 and an edge in the same cycle -> all outputs 0; the next advance requires 4 fresh edges.
REQ-038 HOURLY_CHIME_EN defined, time 00:58:59 in run mode -> chime rises when sec = 8'h55 and falls at 01:00:00.

Source files
------------

// File: rtl/clock_core.sv
// clock_core: BCD 24-hour time-of-day counter advanced once per DIV synchronised tick_in edges.
// Define HOURLY_CHIME_EN to add the registered hourly chime output.
module clock_core #(
    parameter int unsigned DIV = 1000
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       tick_in,
    input  logic       set_mode,
    input  logic [1:0] set_sel,
    input  logic       set_inc,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       sec_pulse
`ifdef HOURLY_CHIME_EN
    ,
    output logic       chime
`endif
);
    localparam logic [15:0] PCNT_LAST = 16'(DIV - 1);

    logic        tick_p0, tick_p1, tick_p2;
    logic        tick_rise;
    logic [15:0] pcnt, pcnt_nxt;
    logic [7:0]  sec_nxt, min_nxt, hour_nxt;
    logic        pulse_nxt;

    // Two-digit BCD increment that wraps to 00 after 'last'; units 9 carries into tens.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Stage p0/p1: metastability synchroniser; stage p2: previous level for edge detect
    always_ff @(posedge CP) begin
        if (CR) begin
            tick_p0 <= 1'b0;
            tick_p1 <= 1'b0;
            tick_p2 <= 1'b0;
        end else begin
            tick_p0 <= tick_in;
            tick_p1 <= tick_p0;
            tick_p2 <= tick_p1;
        end
    end

    assign tick_rise = tick_p1 & ~tick_p2;

    always_comb begin
        pcnt_nxt  = pcnt;
        sec_nxt   = sec;
        min_nxt   = min;
        hour_nxt  = hour;
        pulse_nxt = 1'b0;
        if (set_mode) begin
            // Setting halts timekeeping and discards any partial second.
            pcnt_nxt = '0;
            if (set_inc) begin
                case (set_sel)
                    2'b00:   sec_nxt  = 8'h00;
                    2'b01:   min_nxt  = bcd_inc(min, 8'h59);
                    2'b10:   hour_nxt = bcd_inc(hour, 8'h23);
                    default: ;
                endcase
            end
        end else if (tick_rise) begin
            if (pcnt == PCNT_LAST) begin
                pcnt_nxt  = '0;
                pulse_nxt = 1'b1;
                sec_nxt   = bcd_inc(sec, 8'h59);
                if (sec == 8'h59) begin
                    min_nxt = bcd_inc(min, 8'h59);
                    if (min == 8'h59)
                        hour_nxt = bcd_inc(hour, 8'h23);
                end
            end else begin
                pcnt_nxt = pcnt + 16'd1;
            end
        end
    end

    // Time registers and strobe update on the cycle the edge reaches the prescaler
    always_ff @(posedge CP) begin
        if (CR) begin
            pcnt      <= '0;
            sec       <= 8'h00;
            min       <= 8'h00;
            hour      <= 8'h00;
            sec_pulse <= 1'b0;
        end else begin
            pcnt      <= pcnt_nxt;
            sec       <= sec_nxt;
            min       <= min_nxt;
            hour      <= hour_nxt;
            sec_pulse <= pulse_nxt;
        end
    end

`ifdef HOURLY_CHIME_EN
    // Chime follows the next-state time so it coincides with the displayed :59:55..:59:59.
    always_ff @(posedge CP) begin
        if (CR)
            chime <= 1'b0;
        else
            chime <= ~set_mode && (min_nxt == 8'h59) && (sec_nxt >= 8'h55);
    end
`endif

endmodule

// File: tb/tb_clock_core.sv
// tb_clock_core: randomized scoreboard bench for clock_core with an integer time-of-day model.
`timescale 1ns/1ps
module tb_clock_core;
    localparam int DIV = 4;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       tick_in = 1'b0;
    logic       set_mode = 1'b0;
    logic [1:0] set_sel = 2'b11;
    logic       set_inc = 1'b0;
    logic [7:0] hour, min, sec;
    logic       sec_pulse;
`ifdef HOURLY_CHIME_EN
    logic       chime;
    logic       sm_q = 1'b0;
`endif

    clock_core #(.DIV(DIV)) dut (
        .CP(CP),
        .CR(CR),
        .tick_in(tick_in),
        .set_mode(set_mode),
        .set_sel(set_sel),
        .set_inc(set_inc),
        .hour(hour),
        .min(min),
        .sec(sec),
        .sec_pulse(sec_pulse)
`ifdef HOURLY_CHIME_EN
        ,
        .chime(chime)
`endif
    );

    always #5 CP = ~CP;

    int tod;
    int ecnt;
    int checks;
    int fails;
    int pulse_cnt;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] bcd_of(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {8'h00, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [31:0] cur();
        return {8'h00, hour, min, sec};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each strobe and checks digit legality every cycle
    always @(negedge CP) begin
        checks++;
        if (hour[7:4] > 4'd2 || hour[3:0] > 4'd9 || min[7:4] > 4'd5 || min[3:0] > 4'd9 ||
            sec[7:4] > 4'd5 || sec[3:0] > 4'd9) begin
            fails++;
            $display("FAIL bcd_digit actual=%h:%h:%h required=legal BCD", hour, min, sec);
        end
        if (sec_pulse) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pulse actual=%h:%h:%h required=no pulse", hour, min, sec);
            end else begin
                chk("pulse_time", cur(), exp_q.pop_front());
            end
        end
`ifdef HOURLY_CHIME_EN
        chk("chime", 32'(chime), 32'(!sm_q && min == 8'h59 && sec >= 8'h55 && sec <= 8'h59));
`endif
    end

`ifdef HOURLY_CHIME_EN
    always @(posedge CP) sm_q <= set_mode;
`endif

    task automatic cyc(input int n);
        repeat (n) @(negedge CP);
    endtask

    task automatic model_edge();
        ecnt++;
        if (ecnt == DIV) begin
            ecnt = 0;
            tod = (tod + 1) % 86400;
            exp_q.push_back(bcd_of(tod));
        end
    endtask

    task automatic model_reset();
        tod = 0;
        ecnt = 0;
        exp_q.delete();
    endtask

    task automatic tick(input int hi, input int lo);
        tick_in = 1'b1;
        if (!set_mode) model_edge();
        cyc(hi);
        tick_in = 1'b0;
        cyc(lo);
    endtask

    task automatic rtick();
        tick($urandom_range(3, 1), $urandom_range(3, 1));
    endtask

    task automatic press(input logic [1:0] sel);
        int h, m;
        set_sel = sel;
        set_inc = 1'b1;
        cyc(1);
        set_inc = 1'b0;
        set_sel = 2'b11;
        if (set_mode) begin
            h = tod / 3600;
            m = (tod / 60) % 60;
            case (sel)
                2'b00: tod = tod - (tod % 60);
                2'b01: tod = h * 3600 + ((m + 1) % 60) * 60 + tod % 60;
                2'b10: tod = ((h + 1) % 24) * 3600 + m * 60 + tod % 60;
                default: ;
            endcase
        end
        chk("set_inc", cur(), bcd_of(tod));
    endtask

    task automatic enter_set();
        cyc(5);
        set_mode = 1'b1;
        ecnt = 0;
        cyc(1);
    endtask

    task automatic exit_set();
        cyc(5);
        set_mode = 1'b0;
        ecnt = 0;
        cyc(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        cyc(1);

        // Reset state
        CR = 1'b1;
        cyc(2);
        chk("reset_time", cur(), 32'h0);
        chk("reset_pulse", 32'(sec_pulse), 32'd0);
        CR = 1'b0;
        model_reset();
        cyc(1);
        chk("post_reset_time", cur(), 32'h0);

        // Two seconds from eight ticks; first strobe three cycles after the 4th rise
        pulse_cnt = 0;
        repeat (3) tick(2, 2);
        tick_in = 1'b1;
        model_edge();
        cyc(1);
        chk("latency_c1", 32'(sec_pulse), 32'd0);
        cyc(1);
        chk("latency_c2", 32'(sec_pulse), 32'd0);
        cyc(1);
        chk("latency_c3", 32'(sec_pulse), 32'd1);
        tick_in = 1'b0;
        cyc(2);
        repeat (4) tick(2, 2);
        cyc(5);
        chk("two_pulses", 32'(pulse_cnt), 32'd2);
        chk("sec_02", cur(), 32'h000002);

        // tick_in held high across reset release yields one edge
        tick_in = 1'b1;
        CR = 1'b1;
        cyc(3);
        CR = 1'b0;
        model_reset();
        model_edge();
        cyc(4);
        tick_in = 1'b0;
        cyc(2);
        repeat (3) tick(2, 2);
        cyc(5);
        chk("reset_high_edge", cur(), bcd_of(tod));

        // Reset with pcnt=2 coinciding with an edge discards the partial count
        repeat (2) tick(2, 2);
        p0 = pulse_cnt;
        tick_in = 1'b1;
        cyc(2);
        CR = 1'b1;
        tick_in = 1'b0;
        cyc(1);
        chk("mid_reset_time", cur(), 32'h0);
        chk("mid_reset_pulse", 32'(sec_pulse), 32'd0);
        CR = 1'b0;
        model_reset();
        cyc(1);
        repeat (3) tick(2, 2);
        cyc(5);
        chk("fresh_edges_3", cur(), 32'h0);
        chk("fresh_edges_nopulse", 32'(pulse_cnt - p0), 32'd0);
        tick(2, 2);
        cyc(5);
        chk("fresh_edges_4", cur(), 32'h000001);

        // Edge and set_mode rising together: set_mode wins
        repeat (3) tick(2, 2);
        tick_in = 1'b1;
        cyc(2);
        set_mode = 1'b1;
        ecnt = 0;
        cyc(1);
        chk("setmode_wins", 32'(sec_pulse), 32'd0);
        tick_in = 1'b0;
        cyc(2);

        // Field setting without carry; seconds clear
        while (tod / 3600 != 23) press(2'b10);
        while ((tod / 60) % 60 != 59) press(2'b01);
        press(2'b01);
        chk("min_wrap_no_carry", cur(), 32'h00230000 | {24'h0, sec});
        while ((tod / 60) % 60 != 59) press(2'b01);
        press(2'b00);
        press(2'b11);
        repeat (5) tick(2, 2);
        exit_set();
        chk("set_result", cur(), 32'h00235900);

        // Run to 23:59:59 then midnight rollover with a single strobe
        p0 = pulse_cnt;
        repeat (59 * DIV) rtick();
        cyc(5);
        chk("at_235959", cur(), 32'h00235959);
        repeat (DIV) rtick();
        cyc(5);
        chk("midnight", cur(), 32'h0);
        chk("midnight_pulses", 32'(pulse_cnt - p0), 32'd60);

        // set_inc ignored in run mode
        press(2'b00);
        press(2'b01);
        press(2'b10);

        // Randomized mix of running and setting
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(9, 0) < 7) begin
                repeat ($urandom_range(12, 1)) rtick();
            end else begin
                enter_set();
                repeat ($urandom_range(6, 1)) begin
                    if ($urandom_range(3, 0) == 0) rtick();
                    else press(2'($urandom_range(3, 0)));
                end
                exit_set();
            end
        end
        cyc(6);
        chk("random_end", cur(), bcd_of(tod));

`ifdef HOURLY_CHIME_EN
        // 00:58:59 then through the chime window to 01:00:00
        enter_set();
        while (tod / 3600 != 0) press(2'b10);
        while ((tod / 60) % 60 != 58) press(2'b01);
        press(2'b00);
        exit_set();
        repeat (59 * DIV) rtick();
        repeat (62 * DIV) rtick();
        cyc(5);
        chk("chime_end", cur(), 32'h00010001);
`endif

        cyc(6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
